// File: rtl/alu_cmd_issue.sv
// Command FIFO and issue stage feeding an external combinational 8-bit ALU.
// Registers ALU inputs, traps div-by-zero / illegal opcode, holds the result.
module alu_cmd_issue #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [3:0]               cmd_sel,
   input  logic [7:0]               cmd_a,
   input  logic [7:0]               cmd_b,
   input  logic                     cmd_chain,
   output logic [3:0]               alu_sel,
   output logic [7:0]               alu_a,
   output logic [7:0]               alu_b,
   input  logic [7:0]               alu_out,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [7:0]               res_data,
   output logic [3:0]               res_sel,
   output logic [1:0]               res_err,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [3:0] sel;
      logic [7:0] a;
      logic [7:0] b;
      logic       chain;
   } cmd_t;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      HOLD
   } state_t;

   cmd_t            mem_q [DEPTH];
   cmd_t            cmd_in;
   cmd_t            head;
   state_t          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [3:0]      alu_sel_q, alu_sel_d;
   logic [7:0]      alu_a_q, alu_a_d;
   logic [7:0]      alu_b_q, alu_b_d;
   logic            res_valid_q, res_valid_d;
   logic [7:0]      res_data_q, res_data_d;
   logic [3:0]      res_sel_q, res_sel_d;
   logic [1:0]      res_err_q, res_err_d;
   logic [7:0]      last_res_q, last_res_d;
   logic            push, pop;
   logic            div0, ill;
   logic [7:0]      cap_data;
   logic [1:0]      cap_err;

   assign cmd_in = '{sel: cmd_sel, a: cmd_a, b: cmd_b, chain: cmd_chain};
   assign head   = mem_q[rd_ptr_q];

   always_comb begin
      cmd_ready = !rst && (count_q < CW'(DEPTH));
      push      = cmd_valid && cmd_ready;
      div0      = (alu_sel_q == 4'd3) && (alu_b_q == 8'd0);
      ill       = (alu_sel_q == 4'd2);
      unique case (1'b1)
         div0: begin
            cap_data = 8'h00;
            cap_err  = 2'b01;
         end
         ill: begin
            cap_data = 8'h00;
            cap_err  = 2'b10;
         end
         default: begin
            cap_data = alu_out;
            cap_err  = 2'b00;
         end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      alu_sel_d   = alu_sel_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_sel_d   = res_sel_q;
      res_err_d   = res_err_q;
      last_res_d  = last_res_q;
      unique case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            res_valid_d = 1'b1;
            res_data_d  = cap_data;
            res_sel_d   = alu_sel_q;
            res_err_d   = cap_err;
            last_res_d  = cap_data;
            state_d     = HOLD;
         end
         HOLD: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               if (count_q != '0) begin
                  pop     = 1'b1;
                  state_d = EXEC;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // last_res_q already holds the result completing in a HOLD fast-path pop
      if (pop) begin
         alu_sel_d = head.sel;
         alu_a_d   = head.chain ? last_res_q : head.a;
         alu_b_d   = head.b;
      end
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         alu_sel_q   <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_sel_q   <= '0;
         res_err_q   <= '0;
         last_res_q  <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         alu_sel_q   <= alu_sel_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_sel_q   <= res_sel_d;
         res_err_q   <= res_err_d;
         last_res_q  <= last_res_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= cmd_in;
      end
   end

   assign alu_sel    = alu_sel_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign res_valid  = res_valid_q;
   assign res_data   = res_data_q;
   assign res_sel    = res_sel_q;
   assign res_err    = res_err_q;
   assign fifo_count = count_q;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Bench for alu_cmd_issue: behavioural ALU plus an in-order result model
// driven by directed and random command/backpressure traffic.
module tb_alu_cmd_issue;

   localparam int DEPTH = 4;

   typedef struct {
      logic [7:0] data;
      logic [3:0] sel;
      logic [1:0] err;
   } res_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_sel = '0;
   logic [7:0] cmd_a = '0;
   logic [7:0] cmd_b = '0;
   logic       cmd_chain = 1'b0;
   logic [3:0] alu_sel;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [7:0] alu_out;
   logic       res_valid;
   logic       res_ready = 1'b0;
   logic [7:0] res_data;
   logic [3:0] res_sel;
   logic [1:0] res_err;
   logic [$clog2(DEPTH):0] fifo_count;

   int         checks = 0;
   int         errors = 0;
   res_t       exp_q[$];
   logic [7:0] last = 8'h00;
   int         accepts = 0;
   int         cyc_n = 0;
   int         last_hs = -1;
   bit         meas_gap = 1'b0;
   bit         held_f = 1'b0;
   logic [7:0] held_data;
   logic [3:0] held_sel;
   logic [1:0] held_err;

   always #5 clk = ~clk;

   alu_cmd_issue #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_sel    (cmd_sel),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .cmd_chain  (cmd_chain),
      .alu_sel    (alu_sel),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_out    (alu_out),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_sel    (res_sel),
      .res_err    (res_err),
      .fifo_count (fifo_count)
   );

   // Stand-in ALU; sel 2 and div-by-zero return junk that must be trapped
   function automatic logic [7:0] alu_fn(input logic [3:0] s,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
      logic [15:0] t;
      case (s)
         4'h0: return a + b;
         4'h1: return a - b;
         4'h2: return 8'hA5;
         4'h3: return (b == 0) ? 8'hFF : a / b;
         4'h4: return a << b[2:0];
         4'h5: return a >> b[2:0];
         4'h6: begin
            t = {a, a} << b[2:0];
            return t[15:8];
         end
         4'h7: begin
            t = {a, a} >> b[2:0];
            return t[7:0];
         end
         4'h8: return a & b;
         4'h9: return a | b;
         4'hA: return a ^ b;
         4'hB: return ~(a & b);
         4'hC: return ~(a | b);
         4'hD: return ~(a ^ b);
         4'hE: return {7'd0, a > b};
         default: return {7'd0, a == b};
      endcase
   endfunction

   always_comb alu_out = alu_fn(alu_sel, alu_a, alu_b);

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_push(input logic [3:0] s, input logic [7:0] a,
                             input logic [7:0] b, input logic ch);
      res_t r;
      logic [7:0] ae;
      ae = ch ? last : a;
      r.sel = s;
      if (s == 4'd3 && b == 8'd0) begin
         r.data = 8'h00;
         r.err  = 2'b01;
      end else if (s == 4'd2) begin
         r.data = 8'h00;
         r.err  = 2'b10;
      end else begin
         r.data = alu_fn(s, ae, b);
         r.err  = 2'b00;
      end
      last = r.data;
      exp_q.push_back(r);
   endtask

   // Inputs set at negedge; handshakes resolved just before the next posedge
   task automatic cyc(input logic v, input logic [3:0] s,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic ch, input logic rr, input logic r);
      res_t e;
      cmd_valid = v;
      cmd_sel   = s;
      cmd_a     = a;
      cmd_b     = b;
      cmd_chain = ch;
      res_ready = rr;
      rst       = r;
      #1;
      if (held_f) begin
         chk("hold_valid", res_valid, 1);
         chk("hold_data", res_data, held_data);
         chk("hold_sel", res_sel, held_sel);
         chk("hold_err", res_err, held_err);
      end
      if (r) begin
         exp_q.delete();
         last   = 8'h00;
         held_f = 1'b0;
      end else begin
         if (v && cmd_ready) begin
            model_push(s, a, b, ch);
            accepts++;
         end
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               chk("spurious_res", res_valid, 0);
            end else begin
               e = exp_q.pop_front();
               chk("res_data", res_data, e.data);
               chk("res_sel", res_sel, e.sel);
               chk("res_err", res_err, e.err);
            end
            if (meas_gap && last_hs >= 0) chk("gap", cyc_n - last_hs, 2);
            last_hs = cyc_n;
         end
         held_f    = res_valid && !res_ready;
         held_data = res_data;
         held_sel  = res_sel;
         held_err  = res_err;
      end
      cyc_n++;
      @(negedge clk);
   endtask

   task automatic idle(input logic rr);
      cyc(1'b0, 4'd0, 8'd0, 8'd0, 1'b0, rr, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < 80; i++) begin
         if (exp_q.size() == 0 && !res_valid) break;
         idle(1'b1);
      end
      chk("drain_left", exp_q.size(), 0);
      chk("drain_valid", res_valid, 0);
   endtask

   initial begin
      @(negedge clk);
      cyc(1'b0, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_alu", {alu_sel, alu_a, alu_b}, 0);
      chk("rst_res", {res_data, res_sel, res_err}, 0);
      rst = 1'b0;
      #1 chk("ready_after_rst", cmd_ready, 1);

      // Latency: push at E, alu_* after E+1, res_valid after E+2
      cyc(1'b1, 4'd0, 8'h05, 8'h03, 1'b0, 1'b0, 1'b0);
      chk("lat_e0_valid", res_valid, 0);
      idle(1'b0);
      chk("lat_e1_alu", {alu_sel, alu_a, alu_b}, {4'd0, 8'h05, 8'h03});
      chk("lat_e1_valid", res_valid, 0);
      idle(1'b0);
      chk("lat_e2_valid", res_valid, 1);
      chk("add_data", res_data, 8'h08);
      chk("add_err", {res_sel, res_err}, 0);
      drain();

      // Chain and traps
      cyc(1'b1, 4'd0, 8'd10, 8'd20, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 4'd1, 8'd99, 8'd5, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 4'd3, 8'd9, 8'd0, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 4'd2, 8'd4, 8'd4, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 4'd3, 8'd9, 8'd2, 1'b0, 1'b1, 1'b0);
      drain();

      // Backpressure: exactly DEPTH+1 accepts
      accepts = 0;
      for (int i = 0; i < 10; i++)
         cyc(1'b1, 4'(i + 8), 8'(i * 17), 8'(i + 3), 1'b0, 1'b0, 1'b0);
      chk("full_accepts", accepts, DEPTH + 1);
      chk("full_ready", cmd_ready, 0);
      chk("full_count", fifo_count, DEPTH);
      meas_gap = 1'b1;
      last_hs  = -1;
      drain();
      meas_gap = 1'b0;

      // Simultaneous push and pop with two entries queued
      for (int i = 0; i < 3; i++)
         cyc(1'b1, 4'd0, 8'(i), 8'd1, 1'b0, 1'b0, 1'b0);
      chk("pp_pre_count", fifo_count, 2);
      chk("pp_pre_valid", res_valid, 1);
      cyc(1'b1, 4'd9, 8'h3C, 8'hC3, 1'b0, 1'b1, 1'b0);
      chk("pp_count", fifo_count, 2);
      drain();

      // Random traffic, many pointer wraps
      accepts = 0;
      for (int i = 0; i < 400; i++) begin
         cyc(1'($urandom_range(0, 1)), 4'($urandom),
             8'($urandom),
             ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom),
             1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 3) != 0), 1'b0);
      end
      drain();
      chk("rand_wrap", accepts >= 3 * DEPTH, 1);

      // Reset mid-operation with three queued and one held
      for (int i = 0; i < 4; i++)
         cyc(1'b1, 4'd0, 8'(40 + i), 8'd1, 1'b0, 1'b0, 1'b0);
      chk("mid_count", fifo_count, 3);
      chk("mid_valid", res_valid, 1);
      cyc(1'b0, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
      chk("mid_rst_ready", cmd_ready, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_count", fifo_count, 0);
      chk("post_rst_valid", res_valid, 0);
      chk("post_rst_ready", cmd_ready, 1);
      cyc(1'b1, 4'd0, 8'd77, 8'd6, 1'b1, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);
      chk("rst_chain_data", res_data, 8'd6);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=%0d exp=done", cyc_n);
      $fatal(1);
   end

endmodule
